// File: rtl/if_fetch_fsm.sv
// Instruction-fetch stage: PC generation, single-outstanding imem fetch,
// one-entry instruction buffer and valid/ready_go producer for IF/ID.
module if_fetch_fsm #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump,
  input  logic [BUS_WIDTH-1:0]  jump_addr,
  input  logic                  hold,
  input  logic                  allow_in_id,
  output logic                  valid_if,
  output logic                  ready_go_if,
  output logic [BUS_WIDTH-1:0]  pc_if,
  output logic [DATA_WIDTH-1:0] instruction_if,
  output logic                  imem_req,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata
);

  localparam int I_IDLE = 0;
  localparam int I_REQ  = 1;
  localparam int I_WAIT = 2;
  localparam int I_DROP = 3;
  localparam int I_FULL = 4;

  localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(PC_STEP);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_WAIT = 5'b00100,
    S_DROP = 5'b01000,
    S_FULL = 5'b10000
  } state_e;

  state_e                state_q;
  logic [BUS_WIDTH-1:0]  fetch_pc_q;
  logic [BUS_WIDTH-1:0]  pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  handover;

  assign ready_go_if    = !hold;
  assign valid_if       = state_q[I_FULL] && !jump;
  assign handover       = valid_if && ready_go_if && allow_in_id;
  assign imem_req       = state_q[I_REQ];
  assign imem_addr      = fetch_pc_q;
  assign pc_if          = pc_q;
  assign instruction_if = instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      instr_q    <= '0;
    end else begin
      unique case (1'b1)
        state_q[I_IDLE]: state_q <= S_REQ;
        state_q[I_REQ]: begin
          // Memory latches the address only at gnt, so retargeting is safe
          if (jump) fetch_pc_q <= jump_addr;
          if (imem_gnt) state_q <= jump ? S_DROP : S_WAIT;
        end
        state_q[I_WAIT]: begin
          if (imem_rvalid) begin
            if (!jump) begin
              pc_q    <= fetch_pc_q;
              instr_q <= imem_rdata;
              state_q <= S_FULL;
            end else begin
              fetch_pc_q <= jump_addr;
              state_q    <= S_REQ;
            end
          end else if (jump) begin
            fetch_pc_q <= jump_addr;
            state_q    <= S_DROP;
          end
        end
        state_q[I_DROP]: begin
          if (jump) fetch_pc_q <= jump_addr;
          if (imem_rvalid) state_q <= S_REQ;
        end
        state_q[I_FULL]: begin
          if (jump) begin
            pc_q       <= '0;
            instr_q    <= '0;
            fetch_pc_q <= jump_addr;
            state_q    <= S_REQ;
          end else if (handover) begin
            fetch_pc_q <= pc_q + STEP;
            state_q    <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_fsm.md
Name: if_fetch_fsm

Overview:
Instruction-fetch stage and producer side of the valid / ready_go / allow_in pipeline handshake consumed by the IF/ID register.
- Generates the PC, issues single-outstanding fetches to instruction memory over a req/gnt/rvalid interface, and buffers the returned word.
- Presents {pc_if, instruction_if, valid_if, ready_go_if} to the IF/ID stage.
- Handles branch/jump redirects arriving at any point of a fetch, including discarding a response already in flight.

Parameters:
BUS_WIDTH, 32, PC/address width.
DATA_WIDTH, 32, instruction width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
PC_STEP, 4, sequential PC increment.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
jump  in  1  redirect request; acts as cancel for the current fetch and buffer.
jump_addr  in  BUS_WIDTH  redirect target.
hold  in  1  stall request for IF; ready_go_if = !hold.
allow_in_id  in  1  IF/ID stage can accept this cycle.
valid_if  out  1  buffered instruction valid.
ready_go_if  out  1  IF stage may hand over its instruction.
pc_if  out  BUS_WIDTH  PC of buffered instruction.
instruction_if  out  DATA_WIDTH  buffered instruction.
imem_req  out  1  fetch request.
imem_addr  out  BUS_WIDTH  fetch address.
imem_gnt  in  1  request accepted this cycle; sampled only when imem_req=1.
imem_rvalid  in  1  response data valid; at most one per granted request, earliest 1 cycle after gnt.
imem_rdata  in  DATA_WIDTH  response data.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; fetch PC = RESET_PC; buffer cleared.
- valid_if=0, imem_req=0, pc_if=0, instruction_if=0.
- ready_go_if follows !hold combinationally.

Handover:
- Handover occurs when valid_if && ready_go_if && allow_in_id && !jump.
- valid_if = (state==FULL) && !jump.

State machine (one-hot, 5 states):
- IDLE: next cycle → REQ. Used once after reset.
- REQ: imem_req=1, imem_addr = fetch PC.
  - jump && gnt → DROP, fetch PC = jump_addr.
  - jump && !gnt → stay REQ, fetch PC = jump_addr. Address may change while ungranted; memory samples the address only at gnt.
  - gnt → WAIT.
  - otherwise stay REQ.
- WAIT: imem_req=0.
  - rvalid && !jump → capture rdata and fetch PC into the buffer → FULL.
  - rvalid && jump → discard data → REQ at jump_addr.
  - !rvalid && jump → DROP, fetch PC = jump_addr.
- DROP: waits for the in-flight response of a cancelled fetch.
  - rvalid → discard data → REQ.
  - jump in DROP → fetch PC = jump_addr, stay DROP (or → REQ if rvalid in the same cycle).
- FULL: buffer holds the instruction; outputs stable.
  - jump → clear buffer → REQ at jump_addr. Has priority over handover; the instruction is not delivered.
  - Handover → REQ with fetch PC = buffered pc + PC_STEP.
  - hold or !allow_in_id → stay FULL, buffer unchanged.

Other rules:
- PC arithmetic is modulo 2^BUS_WIDTH; wrap from 32'hFFFF_FFFC to 0 is legal.
- Latency, zero wait states (gnt in first REQ cycle, rvalid next cycle, immediate handover): REQ→WAIT→FULL gives one instruction per 3 cycles. No prefetch.
- rvalid outside WAIT/DROP is a protocol error and is ignored.
- jump_addr is used unmodified; alignment is the caller's responsibility.
- Reset asserted mid-fetch returns to IDLE immediately; a later stray rvalid is ignored.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, allow_in_id=1, hold=0 → imem_addr 0,4,8; valid_if pulses with pc_if 0,4,8 every 3rd cycle; instruction_if equals the returned rdata.
- Downstream stall: allow_in_id=0 for 5 cycles while FULL at pc=4 → valid_if stays 1, pc_if/instruction_if stable, imem_req=0; after release, next imem_addr=8.
- hold=1 while FULL → ready_go_if=0, no handover, state stays FULL; hold=0 → handover, then fetch pc+4.
- jump to 0x100 in WAIT without rvalid → DROP; the following rvalid data (0xDEADBEEF) is never presented; next request imem_addr=0x100; valid_if later shows pc_if=0x100.
- jump to 0x200 in FULL in the same cycle as allow_in_id=1 → valid_if=0 that cycle, no handover, next imem_addr=0x200.
- gnt held 0 for 4 cycles with jump to 0x40 in cycle 2 → imem_req stays 1, imem_addr switches to 0x40, fetch proceeds from 0x40; rst_n pulsed low in WAIT → outputs 0 immediately, restart at RESET_PC.
